// File: rtl/dsram_responder.sv
// dsram_responder: responder end of the data SRAM request interface.
// Accepts read/write requests on an addr_ok handshake, performs the access on
// an internal word-addressed memory at the accepting edge, and returns in-order
// data_ok/rdata pulses LATENCY cycles after acceptance.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   data_sram_en          request valid
//   data_sram_we          write byte mask, nonzero marks a write
//   data_sram_size        00 byte, 01 half, 10/11 word
//   data_sram_addr        byte address (bits above ADDR_W+1 alias)
//   data_sram_wdata       write data already placed in its byte lanes
//   data_sram_addr_ok     combinational accept indication
//   data_sram_data_ok     registered one-cycle response pulse
//   data_sram_rdata       registered read data, valid with data_ok
//
// Optional feature macro: DSRAM_RESP_RANDOM_STALL_EN
//   When defined, a 16-bit LFSR (seed 16'hACE1) forces addr_ok low whenever its
//   two low bits are zero, injecting roughly 25% accept stalls.

module dsram_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int unsigned WORDS = 1 << ADDR_W;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // One pending response slot.
   typedef struct packed {
      logic            vld;
      logic [CD_W-1:0] cd;
      logic [31:0]     rdata;
   } entry_t;

   entry_t            q_q [DEPTH];
   entry_t            q_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              data_ok_q, data_ok_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [31:0]       mem_q [WORDS];

   logic              addr_ok_c;
   logic              accept_c;
   logic              retire_c;
   logic              is_write_c;
   logic [ADDR_W-1:0] idx_c;
   logic [3:0]        lane_mask_c;
   logic [3:0]        wr_mask_c;
   logic [31:0]       rd_word_c;

   // Address bits above the word index are ignored so the memory aliases.
   if (ADDR_W + 2 < 32) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^data_sram_addr[31:ADDR_W+2];
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

`ifdef DSRAM_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`endif

   // Accept indication: room in the pending queue, never during reset.
   always_comb begin
      addr_ok_c = !reset && (count_q < CNT_W'(DEPTH));
`ifdef DSRAM_RESP_RANDOM_STALL_EN
      if (lfsr_q[1:0] == 2'b00) begin
         addr_ok_c = 1'b0;
      end
`endif
   end

   // Request decode: word index, byte lanes, effective write mask.
   always_comb begin
      idx_c       = data_sram_addr[ADDR_W+1:2];
      is_write_c  = |data_sram_we;
      accept_c    = data_sram_en && addr_ok_c;
      lane_mask_c = 4'b0000;
      case (data_sram_size)
         2'b00: lane_mask_c = 4'b0001 << data_sram_addr[1:0];
         2'b01: begin
            // Misaligned halves select no lanes.
            if (!data_sram_addr[0]) begin
               lane_mask_c = data_sram_addr[1] ? 4'b1100 : 4'b0011;
            end
         end
         default: begin
            if (data_sram_addr[1:0] == 2'b00) begin
               lane_mask_c = 4'b1111;
            end
         end
      endcase
      wr_mask_c = lane_mask_c & data_sram_we;
      rd_word_c = mem_q[idx_c];
   end

   // Memory array: written at the accepting edge, never reset.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask_c[b]) begin
               mem_q[idx_c][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
         end
      end
   end

   // Pending queue: countdowns, head retire into the response register, push.
   always_comb begin
      q_d       = q_q;
      head_d    = head_q;
      tail_d    = tail_q;
      data_ok_d = 1'b0;
      rdata_d   = rdata_q;

      retire_c  = q_q[head_q].vld && (q_q[head_q].cd == '0);

      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (q_q[i].vld && (q_q[i].cd != '0)) begin
            q_d[i].cd = q_q[i].cd - CD_W'(1);
         end
      end

      if (retire_c) begin
         data_ok_d          = 1'b1;
         rdata_d            = q_q[head_q].rdata;
         q_d[head_q].vld    = 1'b0;
         head_d             = ptr_inc(head_q);
      end

      // A free tail slot never aliases the retiring head, so both may proceed.
      if (accept_c) begin
         q_d[tail_q].vld   = 1'b1;
         q_d[tail_q].cd    = CD_W'(LATENCY - 1);
         q_d[tail_q].rdata = is_write_c ? 32'h0 : rd_word_c;
         tail_d            = ptr_inc(tail_q);
      end

      count_d = count_q + CNT_W'(accept_c) - CNT_W'(retire_c);
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_q[i] <= '0;
         end
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         data_ok_q <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         q_q       <= q_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   assign data_sram_addr_ok = addr_ok_c;
   assign data_sram_data_ok = data_ok_q;
   assign data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder. Two instances (LATENCY 2 and 4,
// DEPTH 2) see the same request stream; each request is held until both have
// accepted it. A request-level reference model predicts, per instance, the
// cycle of every data_ok (acceptance edge + LATENCY), its rdata, and addr_ok
// from the number of requests still awaiting their response.
`timescale 1ns/1ps

module tb_dsram_responder;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 2;
   localparam int          NI    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        en      [NI];
   logic [3:0]  we;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok [NI];
   logic        data_ok [NI];
   logic [31:0] rdata   [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dsram_responder #(
         .ADDR_W (AW),
         .LATENCY((g == 0) ? 2 : 4),
         .DEPTH  (DEPTH)
      ) u_dut (
         .clk              (clk),
         .reset            (reset),
         .data_sram_en     (en[g]),
         .data_sram_we     (we),
         .data_sram_size   (size),
         .data_sram_addr   (addr),
         .data_sram_wdata  (wdata),
         .data_sram_addr_ok(addr_ok[g]),
         .data_sram_data_ok(data_ok[g]),
         .data_sram_rdata  (rdata[g])
      );
   end

   int unsigned n_pass;
   int unsigned n_chk;
   int unsigned cyc;
   int unsigned n_room;
   int unsigned n_low;
   logic [31:0] mref [1 << AW];
   int unsigned pend_cyc [NI][$];
   logic [31:0] pend_dat [NI][$];

   function automatic int unsigned lat_of(input int g);
      return (g == 0) ? 2 : 4;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'b00:   return 4'b0001 << lo;
         2'b01:   return (lo == 2'b00) ? 4'b0011 : ((lo == 2'b10) ? 4'b1100 : 4'b0000);
         default: return (lo == 2'b00) ? 4'b1111 : 4'b0000;
      endcase
   endfunction

   function automatic logic has_room(input int g);
`ifdef DSRAM_RESP_RANDOM_STALL_EN
      return addr_ok[g];
`else
      return pend_cyc[g].size() < DEPTH;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance one clock and check every instance's outputs for the new cycle.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int g = 0; g < NI; g++) begin
         if (pend_cyc[g].size() != 0 && pend_cyc[g][0] == cyc) begin
            chk($sformatf("data_ok[%0d]", g), 32'(data_ok[g]), 32'd1);
            chk($sformatf("rdata[%0d]", g), rdata[g], pend_dat[g][0]);
            void'(pend_cyc[g].pop_front());
            void'(pend_dat[g].pop_front());
         end else begin
            chk($sformatf("data_ok_idle[%0d]", g), 32'(data_ok[g]), 32'd0);
         end
`ifdef DSRAM_RESP_RANDOM_STALL_EN
         if (pend_cyc[g].size() >= DEPTH) begin
            chk($sformatf("addr_ok_full[%0d]", g), 32'(addr_ok[g]), 32'd0);
         end else begin
            n_room++;
            if (!addr_ok[g]) n_low++;
         end
`else
         chk($sformatf("addr_ok[%0d]", g), 32'(addr_ok[g]),
             32'(pend_cyc[g].size() < DEPTH));
`endif
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present one request and hold it until every instance has accepted it.
   task automatic issue(input logic [3:0] w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
      logic [31:0] exp_r;
      logic [3:0]  m;
      logic [AW-1:0] ix;
      logic        done [NI];
      logic        all_done;
      int          spent;
      ix    = a[AW+1:2];
      exp_r = (w != 4'b0000) ? 32'h0 : mref[ix];
      m     = lane_mask(sz, a[1:0]) & w;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) mref[ix][8*b +: 8] = d[8*b +: 8];
      end
      we = w; size = sz; addr = a; wdata = d;
      for (int g = 0; g < NI; g++) done[g] = 1'b0;
      all_done = 1'b0;
      spent    = 0;
      while (!all_done && spent < 64) begin
         for (int g = 0; g < NI; g++) begin
            en[g] = !done[g];
            if (!done[g] && has_room(g)) begin
               pend_cyc[g].push_back(cyc + 1 + lat_of(g));
               pend_dat[g].push_back(exp_r);
               done[g] = 1'b1;
            end
         end
         tick();
         spent++;
         all_done = 1'b1;
         for (int g = 0; g < NI; g++) if (!done[g]) all_done = 1'b0;
      end
      for (int g = 0; g < NI; g++) en[g] = 1'b0;
      chk("issue_accepted", 32'(all_done), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  w;
      logic [31:0] a;
      int unsigned pick;
      n_pass = 0; n_chk = 0; cyc = 0; n_room = 0; n_low = 0;
      reset = 1'b1;
      for (int g = 0; g < NI; g++) en[g] = 1'b0;
      we = 4'h0; size = 2'b10; addr = 32'h0; wdata = 32'h0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("rst_addr_ok[%0d]", g), 32'(addr_ok[g]), 32'd0);
         chk($sformatf("rst_data_ok[%0d]", g), 32'(data_ok[g]), 32'd0);
         chk($sformatf("rst_rdata[%0d]", g), rdata[g], 32'h0);
      end
      reset = 1'b0;
      idle(2);

      // Word write then read of the same word.
      issue(4'hF, 2'b10, 32'h10, 32'hDEADBEEF);
      issue(4'h0, 2'b10, 32'h10, 32'h0);
      // Byte and half lanes.
      issue(4'hF, 2'b00, 32'h11, 32'h0000AA00);
      issue(4'hF, 2'b01, 32'h12, 32'h12340000);
      issue(4'h0, 2'b10, 32'h10, 32'h0);
      // Misaligned word and half writes leave memory unchanged.
      issue(4'hF, 2'b10, 32'h13, 32'hFFFFFFFF);
      issue(4'hF, 2'b01, 32'h11, 32'hFFFFFFFF);
      issue(4'h0, 2'b10, 32'h10, 32'h0);
      // Aliased address reaches the same word.
      issue(4'h0, 2'b00, 32'hABCD_F010, 32'h0);
      idle(6);

      // Initialise the word range used by random traffic.
      for (int i = 0; i < 16; i++) issue(4'hF, 2'b10, 32'(i * 4), $urandom);
      idle(6);

      // Back-to-back reads fill the queue.
      for (int i = 0; i < 4; i++) issue(4'h0, 2'b10, 32'(32'h10 + i * 4), 32'h0);
      idle(8);

      // Reset asserted mid-flight discards pending responses.
      issue(4'h0, 2'b10, 32'h14, 32'h0);
      #2 reset = 1'b1;
      #1;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("midrst_data_ok[%0d]", g), 32'(data_ok[g]), 32'd0);
         chk($sformatf("midrst_addr_ok[%0d]", g), 32'(addr_ok[g]), 32'd0);
         pend_cyc[g].delete();
         pend_dat[g].delete();
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(8);

      // Random traffic.
      for (int k = 0; k < 1000; k++) begin
         pick = $urandom_range(0, 3);
         w = (pick < 2) ? 4'h0 : ((pick == 2) ? 4'hF : 4'($urandom));
         a = $urandom;
         a[11:6] = 6'b0;
         issue(w, 2'($urandom), a, $urandom);
         if ($urandom_range(0, 3) == 0) tick();
      end
      idle(10);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("drained[%0d]", g), 32'(pend_cyc[g].size()), 32'd0);
      end
`ifdef DSRAM_RESP_RANDOM_STALL_EN
      chk("stall_rate_in_range",
          32'((n_low * 100 >= n_room * 20) && (n_low * 100 <= n_room * 30)), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
